versatile_fifo_sync_fifo: RTL and testbench

Parametrised single-clock FIFO built around an internal simple dual-port RAM (one write port, one registered read port). It generalises the fifo storage layer to arbitrary width and depth and adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses, synchronous clear, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain.

---
 rtl/versatile_fifo_sync_fifo_pkg.sv | 18 +
 rtl/versatile_fifo_sync_fifo_if.sv | 29 ++
 rtl/versatile_fifo_sync_ram.sv | 27 ++
 rtl/versatile_fifo_sync_fifo.sv | 147 ++++++++++++++
 tb/tb_versatile_fifo_sync_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/versatile_fifo_sync_fifo_pkg.sv
// Shared constants and helpers for the versatile_fifo blocks.
package versatile_fifo_sync_fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam bit FWFT_OFF = 1'b0;
  localparam bit FWFT_ON  = 1'b1;

  // Bits needed to encode the values 0..n-1 (at least 1).
  function automatic int unsigned vf_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/versatile_fifo_sync_fifo_if.sv
// Producer/consumer bundle of the synchronous FIFO.
interface versatile_fifo_sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/versatile_fifo_sync_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// A read of the address being written returns the old contents.
module versatile_fifo_sync_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage write and registered read share one clock edge.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/versatile_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, error pulses,
// synchronous clear and optional first-word-fall-through read mode.
module versatile_fifo_sync_fifo
  import versatile_fifo_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          FWFT       = FWFT_OFF,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input logic                       clk,
  input logic                       rst,
  versatile_fifo_sync_fifo_if.slave bus
);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned CntW  = vf_clog2(Depth + 1);

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CntW-1:0]       cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  ptr_t  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_raddr;
  cnt_t  count_q, count_d, ram_cnt;
  data_t rd_data_q, rd_data_d, byp_data_q, ram_rdata, prefetch;
  logic  full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic  ovf_q, ovf_d, udf_q, udf_d, rd_valid_q, rd_valid_d;
  logic  rd_pend_q, rd_pend_d, head_valid_q, head_valid_d, byp_sel_q, byp_sel_d;
  logic  wr_acc, rd_acc, ram_wr, ram_ren, rd_adv, head_load_wr, head_load_ram;

  assign wr_acc = bus.wr_en && !full_q && !bus.clr;
  assign rd_acc = bus.rd_en && !empty_q && !bus.clr;

  // In FWFT mode the head register holds one word, the RAM holds the rest.
  assign ram_cnt       = count_q - cnt_t'(head_valid_q);
  assign head_load_wr  = (FWFT == FWFT_ON) && wr_acc &&
                         (!head_valid_q || (rd_acc && ram_cnt == '0));
  assign head_load_ram = (FWFT == FWFT_ON) && rd_acc && (ram_cnt != '0);
  assign ram_wr        = wr_acc && !head_load_wr;
  assign rd_adv        = (FWFT == FWFT_ON) ? head_load_ram : rd_acc;

  // FWFT keeps the RAM read port tracking the next-state pointer so the
  // following word is already registered when the head is popped.
  assign ram_raddr = (FWFT == FWFT_ON) ? rd_ptr_d : rd_ptr_q;
  assign ram_ren   = (FWFT == FWFT_ON) ? 1'b1 : rd_acc;
  // A word written at the address being read came back stale from the RAM.
  assign prefetch  = byp_sel_q ? byp_data_q : ram_rdata;

  // Next-state: pointers, count, head/output register and registered flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + ptr_t'(ram_wr);
    rd_ptr_d     = rd_ptr_q + ptr_t'(rd_adv);
    count_d      = count_q;
    head_valid_d = head_valid_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    rd_pend_d    = (FWFT == FWFT_OFF) && rd_acc;
    if (wr_acc && !rd_acc)      count_d = count_q + cnt_t'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - cnt_t'(1);
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    if (FWFT == FWFT_ON) begin
      if (head_load_ram)     rd_data_d = prefetch;
      else if (head_load_wr) rd_data_d = bus.wr_data;
      if (bus.clr)                             head_valid_d = 1'b0;
      else if (head_load_ram || head_load_wr)  head_valid_d = 1'b1;
      else if (rd_acc)                         head_valid_d = 1'b0;
      rd_valid_d = head_valid_d;
    end else begin
      if (rd_pend_q) rd_data_d = ram_rdata;
      rd_valid_d = rd_pend_q;
    end
    byp_sel_d = (FWFT == FWFT_ON) && ram_wr && (wr_ptr_q == rd_ptr_d);
    full_d    = (count_d == cnt_t'(Depth));
    empty_d   = (count_d == '0);
    af_d      = (count_d >= cnt_t'(AF_LEVEL));
    ae_d      = (count_d <= cnt_t'(AE_LEVEL));
    ovf_d     = bus.wr_en && full_q && !bus.clr;
    udf_d     = bus.rd_en && empty_q && !bus.clr;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      head_valid_q <= 1'b0;
      byp_sel_q    <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      af_q         <= (AF_LEVEL == 0);
      ae_q         <= 1'b1;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_pend_q    <= rd_pend_d;
      head_valid_q <= head_valid_d;
      byp_sel_q    <= byp_sel_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      af_q         <= af_d;
      ae_q         <= ae_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  // Bypass data needs no reset; it is qualified by byp_sel_q.
  always_ff @(posedge clk) begin
    byp_data_q <= bus.wr_data;
  end

  versatile_fifo_sync_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (ram_wr),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(bus.wr_data),
    .rd_en_i  (ram_ren),
    .rd_addr_i(ram_raddr),
    .rd_data_o(ram_rdata)
  );

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_versatile_fifo_sync_fifo.sv
// Directed bench: a standard-mode FIFO (AF 12, AE 3) and a FWFT FIFO side by side.
module tb_versatile_fifo_sync_fifo;
  import versatile_fifo_sync_fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  // Stream phases: write enable, read enable, cycles.
  localparam bit PhWr [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit PhRd [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam int PhN  [9] = '{1, 1, 7, 1, 8, 1, 40, 15, 1};

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  versatile_fifo_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
  versatile_fifo_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f_if ();

  versatile_fifo_sync_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FWFT_OFF), .AF_LEVEL(12), .AE_LEVEL(3)
  ) u_std (
    .clk(clk),
    .rst(rst),
    .bus(s_if.slave)
  );

  versatile_fifo_sync_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FWFT_ON)
  ) u_fw (
    .clk(clk),
    .rst(rst),
    .bus(f_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_if.clr = 0; s_if.wr_en = 0; s_if.rd_en = 0; s_if.wr_data = '0;
    f_if.clr = 0; f_if.wr_en = 0; f_if.rd_en = 0; f_if.wr_data = '0;
  endtask

  task automatic test_reset();
    logic [6:0] st;
    rst = 1'b1;
    idle();
    repeat (2) step();
    st = {s_if.full, s_if.empty, s_if.almost_full, s_if.almost_empty, s_if.rd_valid,
          s_if.overflow, s_if.underflow};
    checks++; if (st !== 7'b0101000) begin
      errors++; $display("FAIL reset_std_flags: got %b want %b", st, 7'b0101000);
    end
    checks++; if ({s_if.count, s_if.rd_data} !== 13'h0) begin
      errors++; $display("FAIL reset_std_cnt_data: got %h want 0", {s_if.count, s_if.rd_data});
    end
    st = {f_if.full, f_if.empty, f_if.almost_full, f_if.almost_empty, f_if.rd_valid,
          f_if.overflow, f_if.underflow};
    checks++; if (st !== 7'b0101000) begin
      errors++; $display("FAIL reset_fw_flags: got %b want %b", st, 7'b0101000);
    end
    checks++; if ({f_if.count, f_if.rd_data} !== 13'h0) begin
      errors++; $display("FAIL reset_fw_cnt_data: got %h want 0", {f_if.count, f_if.rd_data});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      s_if.wr_en = 1'b1;
      s_if.wr_data = 8'(i);
      step();
      checks++; if (s_if.count !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, s_if.count, i + 1);
      end
      checks++; if (s_if.full !== (i == 15)) begin
        errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, s_if.full, i == 15);
      end
      checks++; if ({s_if.almost_full, s_if.almost_empty} !== {(i + 1) >= 12, (i + 1) <= 3})
      begin
        errors++; $display("FAIL fill_af_ae[%0d]: got %b%b want %b%b", i, s_if.almost_full,
                           s_if.almost_empty, (i + 1) >= 12, (i + 1) <= 3);
      end
    end
    s_if.wr_data = 8'hEE;
    step();
    s_if.wr_en = 1'b0;
    checks++; if ({s_if.overflow, s_if.full, s_if.count} !== {1'b1, 1'b1, 5'd16}) begin
      errors++; $display("FAIL fill_overflow: got ovf=%b full=%b cnt=%0d want 1 1 16",
                         s_if.overflow, s_if.full, s_if.count);
    end
    step();
    checks++; if (s_if.overflow !== 1'b0) begin
      errors++; $display("FAIL fill_overflow_pulse: got %b want 0", s_if.overflow);
    end
  endtask

  task automatic test_drain_std();
    for (int i = 0; i < 16; i++) begin
      s_if.rd_en = 1'b1;
      step();
      if (i > 0) begin
        checks++; if ({s_if.rd_valid, s_if.rd_data} !== {1'b1, 8'(i - 1)}) begin
          errors++; $display("FAIL drain_data[%0d]: got v=%b d=%h want 1 %h", i,
                             s_if.rd_valid, s_if.rd_data, 8'(i - 1));
        end
      end
    end
    s_if.rd_en = 1'b0;
    step();
    checks++; if ({s_if.rd_valid, s_if.rd_data, s_if.empty} !== {1'b1, 8'd15, 1'b1}) begin
      errors++; $display("FAIL drain_last: got v=%b d=%h e=%b want 1 0f 1",
                         s_if.rd_valid, s_if.rd_data, s_if.empty);
    end
    step();
    checks++; if ({s_if.rd_valid, s_if.rd_data} !== {1'b0, 8'd15}) begin
      errors++; $display("FAIL drain_hold: got v=%b d=%h want 0 0f", s_if.rd_valid,
                         s_if.rd_data);
    end
    s_if.rd_en = 1'b1;
    step();
    s_if.rd_en = 1'b0;
    checks++; if ({s_if.underflow, s_if.count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL drain_underflow: got udf=%b cnt=%0d want 1 0", s_if.underflow,
                         s_if.count);
    end
    step();
    checks++; if ({s_if.underflow, s_if.rd_valid} !== 2'b00) begin
      errors++; $display("FAIL drain_underflow_pulse: got %b%b want 00", s_if.underflow,
                         s_if.rd_valid);
    end
  endtask

  task automatic test_fwft();
    f_if.wr_en = 1'b1; f_if.wr_data = 8'hA5;
    step();
    f_if.wr_en = 1'b0;
    checks++; if ({f_if.rd_valid, f_if.rd_data, f_if.count} !== {1'b1, 8'hA5, 5'd1}) begin
      errors++; $display("FAIL fwft_bypass: got v=%b d=%h c=%0d want 1 a5 1", f_if.rd_valid,
                         f_if.rd_data, f_if.count);
    end
    f_if.wr_en = 1'b1; f_if.wr_data = 8'hB6;
    step();
    f_if.wr_data = 8'hC7;
    step();
    f_if.wr_en = 1'b0;
    checks++; if ({f_if.rd_data, f_if.count} !== {8'hA5, 5'd3}) begin
      errors++; $display("FAIL fwft_head_hold: got d=%h c=%0d want a5 3", f_if.rd_data,
                         f_if.count);
    end
    f_if.rd_en = 1'b1;
    step();
    checks++; if ({f_if.rd_valid, f_if.rd_data, f_if.count} !== {1'b1, 8'hB6, 5'd2}) begin
      errors++; $display("FAIL fwft_pop1: got v=%b d=%h c=%0d want 1 b6 2", f_if.rd_valid,
                         f_if.rd_data, f_if.count);
    end
    step();
    checks++; if ({f_if.rd_valid, f_if.rd_data, f_if.count} !== {1'b1, 8'hC7, 5'd1}) begin
      errors++; $display("FAIL fwft_pop2: got v=%b d=%h c=%0d want 1 c7 1", f_if.rd_valid,
                         f_if.rd_data, f_if.count);
    end
    step();
    f_if.rd_en = 1'b0;
    checks++; if ({f_if.rd_valid, f_if.empty, f_if.count} !== {1'b0, 1'b1, 5'd0}) begin
      errors++; $display("FAIL fwft_pop3: got v=%b e=%b c=%0d want 0 1 0", f_if.rd_valid,
                         f_if.empty, f_if.count);
    end
    // Second word lands in RAM at the read address, then is popped at once.
    f_if.wr_en = 1'b1; f_if.wr_data = 8'h11;
    step();
    f_if.wr_data = 8'h22;
    step();
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b1;
    checks++; if ({f_if.rd_data, f_if.count} !== {8'h11, 5'd2}) begin
      errors++; $display("FAIL fwft_head11: got d=%h c=%0d want 11 2", f_if.rd_data,
                         f_if.count);
    end
    step();
    checks++; if ({f_if.rd_valid, f_if.rd_data, f_if.count} !== {1'b1, 8'h22, 5'd1}) begin
      errors++; $display("FAIL fwft_fresh_pop: got v=%b d=%h c=%0d want 1 22 1",
                         f_if.rd_valid, f_if.rd_data, f_if.count);
    end
    step();
    f_if.rd_en = 1'b0;
    checks++; if ({f_if.empty, f_if.count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL fwft_empty: got e=%b c=%0d want 1 0", f_if.empty, f_if.count);
    end
  endtask

  task automatic test_stream();
    logic [7:0]  q [$];
    logic [7:0]  v, popped, pend_data;
    logic        pend, exp_wr, exp_rd, exp_ovf, exp_udf;
    logic [4:0]  fst_exp, fst_got;
    logic [5:0]  sst_exp, sst_got;
    int unsigned sz;
    v = 8'h40; pend = 1'b0; pend_data = 8'h00;
    for (int p = 0; p < 9; p++) begin
      for (int k = 0; k < PhN[p]; k++) begin
        s_if.wr_en = PhWr[p]; f_if.wr_en = PhWr[p];
        s_if.rd_en = PhRd[p]; f_if.rd_en = PhRd[p];
        s_if.wr_data = v;     f_if.wr_data = v;
        sz = q.size();
        exp_wr  = PhWr[p] && sz < 16;
        exp_rd  = PhRd[p] && sz > 0;
        exp_ovf = PhWr[p] && sz == 16;
        exp_udf = PhRd[p] && sz == 0;
        popped  = 8'h00;
        if (exp_rd) popped = q.pop_front();
        if (exp_wr) q.push_back(v);
        v = v + 8'h01;
        step();
        sz = q.size();
        checks++; if ({f_if.count, s_if.count} !== {5'(sz), 5'(sz)}) begin
          errors++; $display("FAIL stream_count[%0d.%0d]: got fw=%0d std=%0d want %0d", p, k,
                             f_if.count, s_if.count, sz);
        end
        fst_exp = {sz == 16, sz == 0, exp_ovf, exp_udf, sz > 0};
        fst_got = {f_if.full, f_if.empty, f_if.overflow, f_if.underflow, f_if.rd_valid};
        checks++; if (fst_got !== fst_exp) begin
          errors++; $display("FAIL stream_fw_flags[%0d.%0d]: got %b want %b", p, k, fst_got,
                             fst_exp);
        end
        sst_exp = {sz == 16, sz == 0, exp_ovf, exp_udf, sz >= 12, sz <= 3};
        sst_got = {s_if.full, s_if.empty, s_if.overflow, s_if.underflow, s_if.almost_full,
                   s_if.almost_empty};
        checks++; if (sst_got !== sst_exp) begin
          errors++; $display("FAIL stream_std_flags[%0d.%0d]: got %b want %b", p, k, sst_got,
                             sst_exp);
        end
        if (sz > 0) begin
          checks++; if (f_if.rd_data !== q[0]) begin
            errors++; $display("FAIL stream_fw_head[%0d.%0d]: got %h want %h", p, k,
                               f_if.rd_data, q[0]);
          end
        end
        checks++; if (s_if.rd_valid !== pend || (pend && s_if.rd_data !== pend_data)) begin
          errors++; $display("FAIL stream_std_read[%0d.%0d]: got v=%b d=%h want v=%b d=%h", p,
                             k, s_if.rd_valid, s_if.rd_data, pend, pend_data);
        end
        pend = exp_rd;
        pend_data = popped;
      end
    end
    idle();
    step();
  endtask

  task automatic test_clr();
    for (int i = 0; i < 7; i++) begin
      s_if.wr_en = 1'b1; f_if.wr_en = 1'b1;
      s_if.wr_data = 8'(8'h10 + i); f_if.wr_data = 8'(8'h10 + i);
      step();
    end
    checks++; if ({s_if.count, f_if.count} !== {5'd7, 5'd7}) begin
      errors++; $display("FAIL clr_pre_count: got %0d %0d want 7 7", s_if.count, f_if.count);
    end
    s_if.clr = 1'b1; f_if.clr = 1'b1;
    s_if.rd_en = 1'b1; f_if.rd_en = 1'b1;
    s_if.wr_data = 8'h99; f_if.wr_data = 8'h99;
    step();
    idle();
    checks++; if ({s_if.count, s_if.empty, s_if.overflow, s_if.underflow} !== {5'd0, 3'b100})
    begin
      errors++; $display("FAIL clr_std: got c=%0d e=%b o=%b u=%b want 0 1 0 0", s_if.count,
                         s_if.empty, s_if.overflow, s_if.underflow);
    end
    checks++; if ({f_if.count, f_if.empty, f_if.overflow, f_if.underflow, f_if.rd_valid,
                   f_if.rd_data} !== {5'd0, 4'b1000, 8'h10}) begin
      errors++; $display("FAIL clr_fw: got c=%0d e=%b o=%b u=%b v=%b d=%h want 0 1 0 0 0 10",
                         f_if.count, f_if.empty, f_if.overflow, f_if.underflow, f_if.rd_valid,
                         f_if.rd_data);
    end
    f_if.wr_en = 1'b1; f_if.wr_data = 8'h77;
    step();
    f_if.wr_en = 1'b0;
    checks++; if ({f_if.rd_data, f_if.count} !== {8'h77, 5'd1}) begin
      errors++; $display("FAIL clr_after_write: got d=%h c=%0d want 77 1", f_if.rd_data,
                         f_if.count);
    end
  endtask

  task automatic test_rst();
    logic [6:0] st;
    for (int i = 0; i < 3; i++) begin
      s_if.wr_en = 1'b1; f_if.wr_en = 1'b1;
      s_if.wr_data = 8'(8'h21 + i); f_if.wr_data = 8'(8'h21 + i);
      s_if.rd_en = (i == 2);
      step();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    st = {s_if.full, s_if.empty, s_if.almost_full, s_if.almost_empty, s_if.rd_valid,
          s_if.overflow, s_if.underflow};
    checks++; if ({st, s_if.count, s_if.rd_data} !== {7'b0101000, 13'h0}) begin
      errors++; $display("FAIL rst_std: got st=%b c=%0d d=%h want 0101000 0 00", st,
                         s_if.count, s_if.rd_data);
    end
    st = {f_if.full, f_if.empty, f_if.almost_full, f_if.almost_empty, f_if.rd_valid,
          f_if.overflow, f_if.underflow};
    checks++; if ({st, f_if.count, f_if.rd_data} !== {7'b0101000, 13'h0}) begin
      errors++; $display("FAIL rst_fw: got st=%b c=%0d d=%h want 0101000 0 00", st,
                         f_if.count, f_if.rd_data);
    end
    #1 rst = 1'b0;
    step();
    checks++; if (s_if.rd_valid !== 1'b0) begin
      errors++; $display("FAIL rst_std_no_pending: got %b want 0", s_if.rd_valid);
    end
    f_if.wr_en = 1'b1; f_if.wr_data = 8'h5A;
    step();
    f_if.wr_en = 1'b0;
    checks++; if ({f_if.rd_data, f_if.count} !== {8'h5A, 5'd1}) begin
      errors++; $display("FAIL rst_after_write: got d=%h c=%0d want 5a 1", f_if.rd_data,
                         f_if.count);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_drain_std();
    test_fwft();
    test_stream();
    test_clr();
    test_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
